// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the two-read / one-write register bank.
package reg_bank_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_AW    = 4;

    // Any address at or beyond the populated depth is out of range, including
    // addresses that differ from a valid one only in unused upper bits.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/reg_bank_2r1w_if.sv
// Request/response bundle for the register bank: one write channel, two read channels.
interface reg_bank_2r1w_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 4
);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_err;

    logic             ra_en;
    logic [AW-1:0]    ra_addr;
    logic [WIDTH-1:0] ra_data;
    logic             ra_valid;
    logic             ra_err;

    logic             rb_en;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] rb_data;
    logic             rb_valid;
    logic             rb_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        output ra_en, ra_addr,
        output rb_en, rb_addr,
        input  wr_err,
        input  ra_data, ra_valid, ra_err,
        input  rb_data, rb_valid, rb_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  ra_en, ra_addr,
        input  rb_en, rb_addr,
        output wr_err,
        output ra_data, ra_valid, ra_err,
        output rb_data, rb_valid, rb_err
    );

endinterface

// File: rtl/reg_bank_rd_port.sv
// One registered read port: address decode, range check, write-first bypass, output stage.
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [0:DEPTH-1],
    input  logic             wr_ok,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             err
);

    logic             addr_ok_c;
    logic [WIDTH-1:0] word_c;

    // Select the stored word, then let an in-flight write to the same slot win.
    always_comb begin
        addr_ok_c = addr_in_range(32'(addr), DEPTH);
        word_c    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                word_c = regs[i];
            end
        end
        if (wr_ok && (wr_addr == addr)) begin
            word_c = wr_data;
        end
        if (!addr_ok_c) begin
            word_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= en;
            err   <= en && !addr_ok_c;
            if (en) begin
                data <= word_c;
            end
        end
    end

endmodule

// File: rtl/reg_bank_2r1w.sv
// Flip-flop register bank with one write port and two independent 1-cycle read ports.
module reg_bank_2r1w
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic           clk,
    input  logic           reset,
    reg_bank_2r1w_if.slave bus
);

    logic [WIDTH-1:0] regs [0:DEPTH-1];
    logic             wr_ok_c;
    logic             wr_bad_c;

    always_comb begin
        wr_ok_c  = bus.wr_en &&  addr_in_range(32'(bus.wr_addr), DEPTH);
        wr_bad_c = bus.wr_en && !addr_in_range(32'(bus.wr_addr), DEPTH);
    end

    // Storage and write-error flag; reset wins over any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            bus.wr_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_ok_c && (bus.wr_addr == AW'(i))) begin
                    regs[i] <= bus.wr_data;
                end
            end
            bus.wr_err <= wr_bad_c;
        end
    end

    reg_bank_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd_a (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.ra_en),
        .addr    (bus.ra_addr),
        .regs    (regs),
        .wr_ok   (wr_ok_c),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .data    (bus.ra_data),
        .valid   (bus.ra_valid),
        .err     (bus.ra_err)
    );

    reg_bank_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd_b (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.rb_en),
        .addr    (bus.rb_addr),
        .regs    (regs),
        .wr_ok   (wr_ok_c),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .data    (bus.rb_data),
        .valid   (bus.rb_valid),
        .err     (bus.rb_err)
    );

endmodule

// File: doc/reg_bank_2r1w.md
REG_BANK_2R1W -- requirements
Module: reg_bank_2r1w

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register and port.
REQ-002 Parameter DEPTH, default 16, number of registers (2..256).
REQ-003 Parameter AW, default 4, address width; SHALL satisfy 2^AW >= DEPTH; addresses >= DEPTH are out of range.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 wr_en  input  1  write request for this cycle.
REQ-007 wr_addr  input  AW  write register index.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 wr_err  output  1  registered pulse: previous cycle's write was out of range.
REQ-010 ra_en, rb_en  input  1 each  read request, port A / port B.
REQ-011 ra_addr, rb_addr  input  AW each  read index, port A / port B.
REQ-012 ra_data, rb_data  output  WIDTH each  registered read data.
REQ-013 ra_valid, rb_valid  output  1 each  registered: corresponding data is valid this cycle.
REQ-014 ra_err, rb_err  output  1 each  registered: corresponding read was out of range.

Function
REQ-015 Read latency SHALL be exactly 1 cycle: request at edge N, data/valid/err at edge N+1.
REQ-016 xx_valid SHALL equal xx_en of the previous cycle; it is high for one cycle per request.
REQ-017 With xx_en low, xx_data SHALL hold its last value; xx_err SHALL be 0.
REQ-018 In-range write with wr_en high SHALL update register wr_addr at the rising edge.
REQ-019 Out-of-range write SHALL modify no register and SHALL set wr_err high for the next cycle only.
REQ-020 Out-of-range read SHALL return all-zero data with xx_valid=1 and xx_err=1.
REQ-021 Same-cycle read and write to the same in-range address SHALL return the new wr_data (write-first bypass).
REQ-022 Ports A and B SHALL be fully independent; identical addresses on both SHALL return identical data.
REQ-023 Consecutive reads with xx_en held high SHALL be accepted every cycle (no stall, throughput 1/cycle/port).
REQ-024 Address decode SHALL be independent of unused upper address bits only where they are zero; any set bit making addr >= DEPTH is out of range.
REQ-025 No register SHALL be hardwired; register 0 is ordinary storage.

Reset
REQ-026 While reset is high at a rising edge: all DEPTH registers SHALL clear to 0.
REQ-027 While reset is high: ra_data, rb_data SHALL be 0; all valid and err outputs SHALL be 0.
REQ-028 Reset SHALL take priority over a simultaneous write or read; requests in that cycle are discarded.
REQ-029 A read issued the cycle reset deasserts SHALL return 0 for any in-range address not yet written.

Structure
REQ-030 Shared package reg_bank_pkg SHALL hold default WIDTH/DEPTH/AW constants and the range-check function.
REQ-031 One sub-module reg_bank_rd_port (address mux, range check, bypass, output register) SHALL be instantiated twice.
REQ-032 Storage SHALL be a flip-flop array in the top module; no memory macros.

Verification
REQ-033 Reset, then ra_en=1 ra_addr=5 -> next cycle ra_valid=1, ra_data=0x00000000, ra_err=0.
REQ-034 Write addr 3 = 0xDEADBEEF; next cycle ra_addr=3, rb_addr=3 -> both ports 0xDEADBEEF one cycle later.
REQ-035 Same cycle wr_addr=7 data 0x12345678 and ra_addr=7 -> ra_data=0x12345678 next cycle (bypass).
REQ-036 DEPTH=12, AW=4: write addr 13 -> wr_err=1 one cycle, no register changed; read addr 13 -> ra_data=0, ra_err=1.
REQ-037 Fill all 16 registers with value 0x100+i, stream reads 0..15 back-to-back on A and 15..0 on B -> valid every cycle, data matches.
REQ-038 Assert reset mid-stream with ra_en=1 -> valid/err/data 0 during reset; all registers read 0 after release.
